spram_ctl: RTL
==============

// Module: spram_ctl
// PURPOSE
//  Initiator/controller in front of the spram64k 32-bit single-port word memory.
//  Takes byte-addressed load/store requests (byte/half/word, any alignment) from the Forth core.
//  Drives word address, byte-lane write mask and lane-shifted data to spram64k.
//  Splits accesses that cross a word boundary into two memory cycles.
//  Returns read data right-aligned, zero- or sign-extended.
// PARAMETERS
//  AW   16   byte address width (64KB); memory word address = addr[AW-1:2], AW-2 bits
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   synchronous active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   controller can accept (high only in IDLE, low while rst_n=0)
//  req_we     in   1   1=store, 0=load
//  req_sz     in   2   0=byte 1=half 2=word (3 treated as word)
//  req_sx     in   1   loads: 1=sign-extend, 0=zero-extend
//  req_addr   in   AW  byte address
//  req_wdata  in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid  out  1   one-cycle pulse: load data valid / store complete
//  rsp_data   out  32  load result (0 for stores)
//  mem_we     out  1   to spram64k we
//  mem_bmsk   out  4   to spram64k bmsk; bit k=1 enables byte lane k
//  mem_a      out  16  to spram64k a; word address, zero-extended
//  mem_vi     out  32  to spram64k vi
//  mem_vo     in   32  from spram64k vo; valid the cycle after a read access
// BEHAVIOUR
//  - Little-endian lanes: byte offset k (addr[1:0]) = mem bits [8k+7:8k].
//  - n = 1/2/4 bytes; m[7:0] = ((1<<n)-1) << off; acc0 mask = m[3:0], acc1 mask = m[7:4].
//  - Split iff m[7:4]!=0; acc1 word addr = acc0 addr + 1, mod 2^(AW-2) (wraps to 0).
//  - Store lanes: acc0 vi = wdata << 8*off; acc1 vi = wdata >> 8*(4-off).
//  - Reads use the same masks as writes; mem_we=0.
//  - Load result: {d1,d0} >> 8*off, truncated to n bytes, extended per req_sx.
//    d1 = 0 when not split.
//  - FSM: IDLE -> ACC0 -> (ACC1 if split) -> RD0 -> (RD1 if split, load only) -> IDLE.
//  - All mem_* and rsp_* are registered.
//  - Idle values: mem_we=0, mem_bmsk=0, mem_a/mem_vi hold their last value.
//  - Timing, with accept at cycle T (req_valid && req_ready):
//    - T+1: acc0 on mem_*.
//    - T+2: acc1 on mem_* if split.
//    - d0 captured from mem_vo in the cycle after acc0; d1 in the cycle after acc1.
//  - Store rsp_valid: T+2 unsplit, T+3 split.
//  - Load rsp_valid: T+3 unsplit, T+4 split.
//  - req_ready returns high in the cycle after rsp_valid.
//  - Request fields latched at accept; input changes afterwards are ignored.
//  - mem_we is high only during ACC0/ACC1 of a store, and only for one cycle per access.
//  - Reset values (rst_n=0 at a clk edge), from any state:
//    state=IDLE, mem_we=0, mem_bmsk=0, mem_a=0, mem_vi=0, rsp_valid=0, rsp_data=0.
//  - Reset mid-operation:
//    - In-flight op aborted with no rsp.
//    - A split store may leave acc0 written and acc1 not; this is accepted.
//  - No back-pressure on rsp: the consumer must take rsp_valid when it fires.
// TESTING
//  1. Word store 0x1000 <- 0xDEADBEEF:
//     T+1 mem_a=0x0400, bmsk=1111, we=1, vi=0xDEADBEEF; rsp_valid at T+2.
//  2. Byte load 0x1003, sx=1 (after 1):
//     mem_a=0x0400, bmsk=1000, we=0; rsp_data=0xFFFFFFDE at T+3.
//     With sx=0: rsp_data=0x000000DE.
//  3. Word store 0x1006 <- 0x11223344:
//     acc0 a=0x0401, bmsk=1100, vi=0x33440000.
//     acc1 a=0x0402, bmsk=0011, vi=0x00001122; rsp at T+3.
//     Word load 0x1006 -> 0x11223344 at T+4.
//  4. Half store 0xFFFF <- 0xA55A:
//     acc0 a=0x3FFF, bmsk=1000; acc1 a=0x0000, bmsk=0001.
//     Half load 0xFFFF, sx=1 -> 0xFFFFA55A.
//  5. rst_n=0 during ACC1 of the test-3 store:
//     next cycle mem_we=0, bmsk=0, no rsp_valid; req_ready=1 the cycle after rst_n=1.
//  6. req_valid held with two queued word loads:
//     second accepted only when req_ready is high again (4 cycles after the first accept).
//     req_ready=0 for T+1..T+3; responses in order.

Source files
------------

// File: rtl/spram_ctl.sv
// Byte-addressed load/store front end for the spram64k word memory.
// Misaligned accesses that straddle a word boundary are issued as two memory cycles.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a request; only state with req_ready high
// ACC0   | first (or only) memory access on mem_*
// ACC1   | second access of a split op; loads capture d0 here
// RD0    | unsplit load: read data on mem_vo, result computed
// RD1    | split load: d1 on mem_vo, result computed from {d1,d0}
// RESP   | rsp_valid pulse
module spram_ctl #(
  parameter int AW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [1:0]    i_req_sz,
  input  logic          i_req_sx,
  input  logic [AW-1:0] i_req_addr,
  input  logic [31:0]   i_req_wdata,
  output logic          o_rsp_valid,
  output logic [31:0]   o_rsp_data,
  output logic          o_mem_we,
  output logic [3:0]    o_mem_bmsk,
  output logic [15:0]   o_mem_a,
  output logic [31:0]   o_mem_vi,
  input  logic [31:0]   i_mem_vo
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACC0, S_ACC1, S_RD0, S_RD1, S_RESP
  } state_t;

  state_t r_state, w_state_nxt;

  logic          r_we;
  logic [1:0]    r_sz;
  logic          r_sx;
  logic [1:0]    r_off;
  logic          r_split;
  logic [15:0]   r_a1;
  logic [3:0]    r_bmsk1;
  logic [31:0]   r_vi1;
  logic [31:0]   r_d0;

  logic [3:0]    w_lmask;
  logic [7:0]    w_m8;
  logic [63:0]   w_wd64;
  logic [AW-3:0] w_wa0;
  logic [AW-3:0] w_wa1;
  logic [63:0]   w_ld64;
  logic [31:0]   w_sh;
  logic [31:0]   w_res;

  always_comb begin
    w_lmask = 4'b1111;
    case (i_req_sz)
      2'd0:    w_lmask = 4'b0001;
      2'd1:    w_lmask = 4'b0011;
      default: w_lmask = 4'b1111;
    endcase
  end

  assign w_m8   = {4'b0000, w_lmask} << i_req_addr[1:0];
  assign w_wd64 = {32'h0, i_req_wdata} << {i_req_addr[1:0], 3'b000};
  assign w_wa0  = i_req_addr[AW-1:2];
  assign w_wa1  = w_wa0 + {{(AW-3){1'b0}}, 1'b1};

  assign o_req_ready = i_rst_n && (r_state == S_IDLE);

  // Split loads concatenate the captured low word with the second read word.
  assign w_ld64 = (r_state == S_RD1) ? {i_mem_vo, r_d0} : {32'h0, i_mem_vo};
  assign w_sh   = 32'(w_ld64 >> {r_off, 3'b000});

  always_comb begin
    w_res = w_sh;
    case (r_sz)
      2'd0:    w_res = {{24{r_sx & w_sh[7]}}, w_sh[7:0]};
      2'd1:    w_res = {{16{r_sx & w_sh[15]}}, w_sh[15:0]};
      default: w_res = w_sh;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_req_valid) w_state_nxt = S_ACC0;
      S_ACC0:  begin
        if (r_split)   w_state_nxt = S_ACC1;
        else if (r_we) w_state_nxt = S_RESP;
        else           w_state_nxt = S_RD0;
      end
      S_ACC1:  w_state_nxt = r_we ? S_RESP : S_RD1;
      S_RD0:   w_state_nxt = S_RESP;
      S_RD1:   w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      o_mem_we    <= 1'b0;
      o_mem_bmsk  <= 4'b0000;
      o_mem_a     <= 16'h0;
      o_mem_vi    <= 32'h0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= 32'h0;
      r_we        <= 1'b0;
      r_sz        <= 2'd0;
      r_sx        <= 1'b0;
      r_off       <= 2'd0;
      r_split     <= 1'b0;
      r_a1        <= 16'h0;
      r_bmsk1     <= 4'b0000;
      r_vi1       <= 32'h0;
      r_d0        <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      o_rsp_valid <= (w_state_nxt == S_RESP);
      o_mem_we    <= 1'b0;
      o_mem_bmsk  <= 4'b0000;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we       <= i_req_we;
            r_sz       <= i_req_sz;
            r_sx       <= i_req_sx;
            r_off      <= i_req_addr[1:0];
            r_split    <= (w_m8[7:4] != 4'b0000);
            r_a1       <= 16'(w_wa1);
            r_bmsk1    <= w_m8[7:4];
            r_vi1      <= w_wd64[63:32];
            o_mem_we   <= i_req_we;
            o_mem_bmsk <= w_m8[3:0];
            o_mem_a    <= 16'(w_wa0);
            o_mem_vi   <= w_wd64[31:0];
            o_rsp_data <= 32'h0;
          end
        end
        S_ACC0: begin
          if (r_split) begin
            o_mem_we   <= r_we;
            o_mem_bmsk <= r_bmsk1;
            o_mem_a    <= r_a1;
            o_mem_vi   <= r_vi1;
          end
        end
        S_ACC1: begin
          if (!r_we) r_d0 <= i_mem_vo;
        end
        S_RD0, S_RD1: o_rsp_data <= w_res;
        default: ;
      endcase
    end
  end

endmodule
